// File: rtl/user_analog_scan_ctrl.sv
// Wishbone-programmable analog switch scan sequencer: steps a one-hot switch enable
// across the masked channels with break-before-make dead time, dwell and a sample strobe.
module user_analog_scan_ctrl #(
    parameter int NCH = 8,
    parameter int DW  = 16
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    input  logic           wbs_stb_i,
    input  logic           wbs_cyc_i,
    input  logic           wbs_we_i,
    input  logic [3:0]     wbs_sel_i,
    input  logic [31:0]    wbs_adr_i,
    input  logic [31:0]    wbs_dat_i,
    output logic           wbs_ack_o,
    output logic [31:0]    wbs_dat_o,
    output logic [NCH-1:0] sw_en_o,
    output logic           sample_o,
    output logic [3:0]     chan_o,
    output logic           busy_o,
    output logic           irq_o
);

    typedef enum logic [1:0] {IDLE, DEAD, DWELL, SAMPLE} state_t;

    localparam logic [NCH-1:0] ONE_HOT0 = {{(NCH-1){1'b0}}, 1'b1};

    state_t         state;
    logic           continuous;
    logic           irq_en;
    logic           done;
    logic [NCH-1:0] mask;
    logic [DW+7:0]  timing;
    logic [DW-1:0]  cnt;
    logic [3:0]     chan;
    logic [4:0]     first_pick;
    logic [4:0]     next_pick;
    logic           wr;
    logic [1:0]     reg_sel;
    logic           start_req;
    logic           stop_req;
    logic           done_clr;
    logic [DW-1:0]  dead_len;
    logic [DW-1:0]  dwell_len;
    logic [31:0]    rd_data;
    logic           unused_bits;

    // Returns {found, index} of the lowest set mask bit strictly above 'above'.
    function automatic logic [4:0] pick_chan(input logic [NCH-1:0] m, input int above);
        logic [4:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && i > above) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    assign reg_sel     = wbs_adr_i[3:2];
    assign wr          = wbs_ack_o & wbs_stb_i & wbs_cyc_i & wbs_we_i;
    assign start_req   = wr && reg_sel == 2'd0 && wbs_sel_i[0] && wbs_dat_i[0] && !wbs_dat_i[2];
    assign stop_req    = wr && reg_sel == 2'd0 && wbs_sel_i[0] && wbs_dat_i[2];
    assign done_clr    = wr && reg_sel == 2'd3 && wbs_sel_i[0] && wbs_dat_i[1];
    assign first_pick  = pick_chan(mask, -1);
    assign next_pick   = pick_chan(mask, int'(chan));
    assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:24], wbs_sel_i[3]};

    // Counters hold length-1 so a zero setting still yields one cycle.
    assign dead_len  = (timing[DW+7:DW] == 8'd0) ? '0 : DW'(timing[DW+7:DW]) - DW'(1);
    assign dwell_len = (timing[DW-1:0] == '0) ? '0 : timing[DW-1:0] - DW'(1);

    assign chan_o = chan;
    assign irq_o  = done & irq_en;

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd0: rd_data = {28'h0, irq_en, 1'b0, continuous, 1'b0};
            2'd1: rd_data = {{(32-NCH){1'b0}}, mask};
            2'd2: rd_data = 32'(timing);
            default: rd_data = {24'h0, chan, 2'b00, done, busy_o};
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            continuous <= 1'b0;
            irq_en     <= 1'b0;
            mask       <= '0;
            timing     <= '0;
        end else begin
            if (wbs_stb_i && wbs_cyc_i && !wbs_ack_o) begin
                wbs_ack_o <= 1'b1;
                wbs_dat_o <= rd_data;
            end else begin
                wbs_ack_o <= 1'b0;
                wbs_dat_o <= '0;
            end
            if (wr) begin
                case (reg_sel)
                    2'd0: if (wbs_sel_i[0]) begin
                        continuous <= wbs_dat_i[1];
                        irq_en     <= wbs_dat_i[3];
                    end
                    2'd1: for (int i = 0; i < NCH; i++) begin
                        if (wbs_sel_i[i/8]) mask[i] <= wbs_dat_i[i];
                    end
                    2'd2: for (int i = 0; i < DW + 8; i++) begin
                        if (wbs_sel_i[i/8]) timing[i] <= wbs_dat_i[i];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            chan     <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            sw_en_o  <= '0;
            sample_o <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            if (done_clr) done <= 1'b0;
            if (stop_req) begin
                state    <= IDLE;
                sw_en_o  <= '0;
                sample_o <= 1'b0;
                busy_o   <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start_req && first_pick[4]) begin
                        chan   <= first_pick[3:0];
                        done   <= 1'b0;
                        cnt    <= dead_len;
                        busy_o <= 1'b1;
                        state  <= DEAD;
                    end
                    DEAD: if (cnt == '0) begin
                        cnt     <= dwell_len;
                        sw_en_o <= ONE_HOT0 << chan;
                        state   <= DWELL;
                    end else begin
                        cnt <= cnt - DW'(1);
                    end
                    DWELL: if (cnt == '0) begin
                        sample_o <= 1'b1;
                        state    <= SAMPLE;
                    end else begin
                        cnt <= cnt - DW'(1);
                    end
                    SAMPLE: begin
                        sample_o <= 1'b0;
                        sw_en_o  <= '0;
                        if (next_pick[4]) begin
                            chan  <= next_pick[3:0];
                            cnt   <= dead_len;
                            state <= DEAD;
                        end else if (continuous && first_pick[4]) begin
                            chan  <= first_pick[3:0];
                            cnt   <= dead_len;
                            state <= DEAD;
                        end else begin
                            busy_o <= 1'b0;
                            done   <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_user_analog_scan_ctrl.sv
// Bench for user_analog_scan_ctrl: directed and randomized scans compared cycle by
// cycle against a per-channel expansion of the scan timing rules.
module tb_user_analog_scan_ctrl;

    localparam int NCH = 8;
    localparam logic [31:0] A_CTRL = 32'h0;
    localparam logic [31:0] A_MASK = 32'h4;
    localparam logic [31:0] A_TIM  = 32'h8;
    localparam logic [31:0] A_STAT = 32'hC;

    logic           wb_clk_i = 1'b0;
    logic           wb_rst_i;
    logic           wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]     wbs_sel_i;
    logic [31:0]    wbs_adr_i, wbs_dat_i;
    logic           wbs_ack_o;
    logic [31:0]    wbs_dat_o;
    logic [NCH-1:0] sw_en_o;
    logic           sample_o;
    logic [3:0]     chan_o;
    logic           busy_o;
    logic           irq_o;

    always #5 wb_clk_i = ~wb_clk_i;

    user_analog_scan_ctrl #(.NCH(NCH), .DW(16)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wbs_stb_i(wbs_stb_i),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_we_i (wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .sw_en_o  (sw_en_o),
        .sample_o (sample_o),
        .chan_o   (chan_o),
        .busy_o   (busy_o),
        .irq_o    (irq_o)
    );

    typedef struct packed {
        logic [NCH-1:0] sw;
        logic           smp;
        logic [3:0]     ch;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One channel visit: max(dead,1) open cycles, max(dwell,1) closed, one sample cycle.
    task automatic add_chan(input int ch, input int dead, input int dwell);
        exp_t e;
        int nd;
        int nw;
        nd = (dead == 0) ? 1 : dead;
        nw = (dwell == 0) ? 1 : dwell;
        for (int i = 0; i < nd; i++) begin
            e.sw = '0; e.smp = 1'b0; e.ch = 4'(ch);
            expq.push_back(e);
        end
        for (int i = 0; i <= nw; i++) begin
            e.sw = NCH'(1) << ch; e.smp = (i == nw); e.ch = 4'(ch);
            expq.push_back(e);
        end
    endtask

    task automatic add_mask(input logic [NCH-1:0] m, input int dead, input int dwell);
        for (int c = 0; c < NCH; c++) begin
            if (m[c]) add_chan(c, dead, dwell);
        end
    endtask

    function automatic int top_bit(input logic [NCH-1:0] m);
        int r;
        r = 0;
        for (int i = 0; i < NCH; i++) if (m[i]) r = i;
        return r;
    endfunction

    task automatic run_trace(input string tag, input int n, output int nbusy);
        exp_t e;
        nbusy = 0;
        for (int i = 0; i < n; i++) begin
            e = expq.pop_front();
            chk({tag, "_sw"}, 32'(sw_en_o), 32'(e.sw));
            chk({tag, "_sample"}, 32'(sample_o), 32'(e.smp));
            chk({tag, "_chan"}, 32'(chan_o), 32'(e.ch));
            if (busy_o === 1'b1) nbusy++;
            chk({tag, "_busy"}, 32'(busy_o), 32'(1));
            step();
        end
    endtask

    task automatic skip(input int n);
        repeat (n) expq.delete(0);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] sel);
        wbs_adr_i = adr; wbs_dat_i = data; wbs_sel_i = sel; wbs_we_i = 1'b1;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        step();
        chk("wr_ack", 32'(wbs_ack_o), 32'(1));
        step();
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] data);
        wbs_adr_i = adr; wbs_sel_i = 4'hF; wbs_we_i = 1'b0;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        step();
        chk("rd_ack", 32'(wbs_ack_o), 32'(1));
        data = wbs_dat_o;
        step();
        chk("rd_dat_idle", wbs_dat_o, 32'(0));
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    endtask

    task automatic end_check(input string tag, input logic exp_irq, input int exp_chan);
        logic [31:0] rd;
        chk({tag, "_end_busy"}, 32'(busy_o), 32'(0));
        chk({tag, "_end_sw"}, 32'(sw_en_o), 32'(0));
        chk({tag, "_end_sample"}, 32'(sample_o), 32'(0));
        chk({tag, "_end_irq"}, 32'(irq_o), 32'(exp_irq));
        chk({tag, "_end_chan"}, 32'(chan_o), 32'(exp_chan));
        wb_read(A_STAT, rd);
        chk({tag, "_status"}, rd, 32'(exp_chan * 16 + 2));
    endtask

    initial begin
        logic [31:0]    rd;
        int             nb;
        logic [NCH-1:0] m;
        int             dd;
        int             dw;
        logic           ie;

        wb_rst_i = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
        repeat (3) step();
        wb_rst_i = 1'b0;

        // Reset state
        chk("rst_sw", 32'(sw_en_o), 32'(0));
        chk("rst_sample", 32'(sample_o), 32'(0));
        chk("rst_chan", 32'(chan_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_irq", 32'(irq_o), 32'(0));
        chk("rst_ack", 32'(wbs_ack_o), 32'(0));
        chk("rst_dat", wbs_dat_o, 32'(0));
        wb_read(A_CTRL, rd); chk("rst_ctrl", rd, 32'h0);
        wb_read(A_MASK, rd); chk("rst_mask", rd, 32'h0);
        wb_read(A_TIM, rd);  chk("rst_timing", rd, 32'h0);
        wb_read(A_STAT, rd); chk("rst_status", rd, 32'h0);

        // Byte lanes on TIMING and MASK width
        wb_write(A_TIM, 32'hFFAA_1234, 4'hF);
        wb_write(A_TIM, 32'h0000_5600, 4'h2);
        wb_read(A_TIM, rd); chk("timing_lane", rd, 32'h00AA_5634);
        wb_write(A_MASK, 32'hFFFF_FFFF, 4'hF);
        wb_read(A_MASK, rd); chk("mask_width", rd, 32'h0000_00FF);

        // Start and stop together stay idle
        wb_write(A_CTRL, 32'hF, 4'h1);
        chk("ss_busy", 32'(busy_o), 32'(0));
        chk("ss_sw", 32'(sw_en_o), 32'(0));
        wb_read(A_CTRL, rd); chk("ctrl_read", rd, 32'hA);
        wb_read(A_STAT, rd); chk("ss_status", rd, 32'h0);

        // Start with empty mask is ignored
        wb_write(A_CTRL, 32'h0, 4'h1);
        wb_write(A_MASK, 32'h0, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'h1);
        chk("m0_busy", 32'(busy_o), 32'(0));
        wb_read(A_STAT, rd); chk("m0_status", rd, 32'h0);

        // Reference scan: mask 0x05, dead 2, dwell 3, irq enabled
        wb_write(A_TIM, 32'h0002_0003, 4'hF);
        wb_write(A_MASK, 32'h05, 4'hF);
        wb_write(A_CTRL, 32'h9, 4'h1);
        add_mask(8'h05, 2, 3);
        run_trace("ex", expq.size(), nb);
        chk("ex_busy_cycles", 32'(nb), 32'(12));
        end_check("ex", 1'b1, 2);
        wb_write(A_CTRL, 32'hC, 4'h1);
        wb_read(A_STAT, rd); chk("stop_keeps_done", rd, 32'h22);
        wb_write(A_STAT, 32'h2, 4'h2);
        wb_read(A_STAT, rd); chk("w1c_lane", rd, 32'h22);
        wb_write(A_STAT, 32'h2, 4'h1);
        wb_read(A_STAT, rd); chk("w1c_clear", rd, 32'h20);
        chk("w1c_irq", 32'(irq_o), 32'(0));

        // Zero timing
        wb_write(A_TIM, 32'h0, 4'hF);
        wb_write(A_MASK, 32'h03, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'h1);
        add_mask(8'h03, 0, 0);
        run_trace("zt", expq.size(), nb);
        chk("zt_busy_cycles", 32'(nb), 32'(6));
        end_check("zt", 1'b0, 1);

        // Start while busy does not disturb the sequence
        wb_write(A_TIM, 32'h0001_0002, 4'hF);
        wb_write(A_MASK, 32'h06, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'h1);
        add_mask(8'h06, 1, 2);
        run_trace("sb", 3, nb);
        wb_write(A_CTRL, 32'h1, 4'h1);
        skip(2);
        run_trace("sb", expq.size(), nb);
        end_check("sb", 1'b0, 2);

        // Mask shrinks during channel 1 dwell
        wb_write(A_TIM, 32'h0001_0004, 4'hF);
        wb_write(A_MASK, 32'h0F, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'h1);
        add_chan(0, 1, 4);
        add_chan(1, 1, 4);
        run_trace("lr", 7, nb);
        wb_write(A_MASK, 32'h01, 4'hF);
        skip(2);
        run_trace("lr", expq.size(), nb);
        end_check("lr", 1'b0, 1);

        // Continuous wrap 0,7,0,7 then stop mid-dwell
        wb_write(A_TIM, 32'h0001_0006, 4'hF);
        wb_write(A_MASK, 32'h81, 4'hF);
        wb_write(A_CTRL, 32'hB, 4'h1);
        add_chan(0, 1, 6); add_chan(7, 1, 6); add_chan(0, 1, 6); add_chan(7, 1, 6); add_chan(0, 1, 6);
        run_trace("cw", 34, nb);
        wb_write(A_CTRL, 32'hC, 4'h1);
        expq.delete();
        chk("stop_sw", 32'(sw_en_o), 32'(0));
        chk("stop_busy", 32'(busy_o), 32'(0));
        chk("stop_sample", 32'(sample_o), 32'(0));
        chk("stop_irq", 32'(irq_o), 32'(0));
        wb_read(A_STAT, rd); chk("stop_status", rd, 32'h00);

        // Randomized scans
        for (int it = 0; it < 10; it++) begin
            m  = NCH'($urandom_range(255, 1));
            dd = int'($urandom_range(3, 0));
            dw = int'($urandom_range(4, 0));
            ie = 1'($urandom_range(1, 0));
            wb_write(A_TIM, (32'(dd) << 16) | 32'(dw), 4'hF);
            wb_write(A_MASK, 32'(m), 4'hF);
            wb_write(A_CTRL, 32'h1 | (32'(ie) << 3), 4'h1);
            add_mask(m, dd, dw);
            run_trace("rnd", expq.size(), nb);
            end_check("rnd", ie, top_bit(m));
            wb_write(A_STAT, 32'h2, 4'h1);
        end

        // Reset in dwell with an acknowledge in flight
        wb_write(A_TIM, 32'h0001_0005, 4'hF);
        wb_write(A_MASK, 32'h10, 4'hF);
        wb_write(A_CTRL, 32'h9, 4'h1);
        add_chan(4, 1, 5);
        run_trace("rm", 3, nb);
        expq.delete();
        wbs_adr_i = A_STAT; wbs_sel_i = 4'hF; wbs_we_i = 1'b0;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        step();
        chk("rm_ack", 32'(wbs_ack_o), 32'(1));
        chk("rm_dat", wbs_dat_o, 32'h41);
        wb_rst_i = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        step();
        chk("rm_sw", 32'(sw_en_o), 32'(0));
        chk("rm_sample", 32'(sample_o), 32'(0));
        chk("rm_chan", 32'(chan_o), 32'(0));
        chk("rm_busy", 32'(busy_o), 32'(0));
        chk("rm_irq", 32'(irq_o), 32'(0));
        chk("rm_ack_clr", 32'(wbs_ack_o), 32'(0));
        chk("rm_dat_clr", wbs_dat_o, 32'(0));
        step();
        wb_rst_i = 1'b0;
        wb_read(A_MASK, rd); chk("rm_mask", rd, 32'h0);
        wb_read(A_CTRL, rd); chk("rm_ctrl", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
